datapath_ctrl: RTL and testbench

Multicycle controller that sits directly upstream of the register-file/ALU datapath. It accepts a 16-bit instruction on a start strobe, latches it, and drives binary register indices (`readnum`/`writenum`, which feed the one-hot write decoder and the 8:1 read mux) plus the load, select and write strobes. It steps through the read, execute and writeback cycles and then returns to idle.

---
 rtl/datapath_ctrl.sv | 84 ++++++++
 tb/tb_datapath_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multicycle Moore controller sequencing register-file/ALU reads, execute and writeback
module datapath_ctrl #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          s,
   input  logic [15:0]   instr,
   output logic          w,
   output logic          ill,
   output logic [2:0]    readnum,
   output logic [2:0]    writenum,
   output logic          write,
   output logic          loada,
   output logic          loadb,
   output logic          loadc,
   output logic          loads,
   output logic          asel,
   output logic          bsel,
   output logic [1:0]    vsel,
   output logic [1:0]    shift,
   output logic [1:0]    aluop,
   output logic [DW-1:0] sximm8
);
   localparam logic [2:0] WAIT   = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] GET_A  = 3'd2;
   localparam logic [2:0] GET_B  = 3'd3;
   localparam logic [2:0] EXEC   = 3'd4;
   localparam logic [2:0] WR_REG = 3'd5;
   localparam logic [2:0] IMM_WR = 3'd6;

   logic [2:0]  st, nxt;
   logic [15:0] ir;
   logic [2:0]  opc, rn, rd, rm;
   logic [1:0]  op;
   logic        mov_imm, mov_reg, alu, mvn, cmp, two_src, legal;

   assign opc     = ir[15:13];
   assign op      = ir[12:11];
   assign rn      = ir[10:8];
   assign rd      = ir[7:5];
   assign rm      = ir[2:0];
   assign mov_imm = opc == 3'b110 && op == 2'b10;
   assign mov_reg = opc == 3'b110 && op == 2'b00;
   assign alu     = opc == 3'b101;
   assign mvn     = alu && op == 2'b11;
   assign cmp     = alu && op == 2'b01;
   assign two_src = alu && op != 2'b11;
   assign legal   = mov_imm || mov_reg || alu;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         st <= WAIT;
         ir <= '0;
      end else begin
         st <= nxt;
         if (st == WAIT && s) ir <= instr;
      end

   always_comb
      nxt = st == WAIT   ? (s ? DECODE : WAIT) :
            st == DECODE ? (mov_imm ? IMM_WR : (mov_reg || mvn) ? GET_B : two_src ? GET_A : WAIT) :
            st == GET_A  ? GET_B :
            st == GET_B  ? EXEC :
            st == EXEC   ? (cmp ? WAIT : WR_REG) : WAIT;

   // MOV reg and MVN feed Rm through the ALU with operand A forced to zero
   assign w        = st == WAIT;
   assign ill      = st == DECODE && !legal;
   assign readnum  = st == GET_A ? rn : st == GET_B ? rm : 3'd0;
   assign writenum = st == WR_REG ? rd : st == IMM_WR ? rn : 3'd0;
   assign write    = st == WR_REG || st == IMM_WR;
   assign loada    = st == GET_A;
   assign loadb    = st == GET_B;
   assign loadc    = st == EXEC && !cmp;
   assign loads    = st == EXEC && cmp;
   assign asel     = st == EXEC && (mov_reg || mvn);
   assign bsel     = 1'b0;
   assign vsel     = st == IMM_WR ? 2'b10 : 2'b00;
   assign shift    = ir[4:3];
   assign aluop    = op;
   assign sximm8   = {{(DW-8){ir[7]}}, ir[7:0]};
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: scoreboard bench comparing every cycle of datapath_ctrl outputs against a spec model
module tb_datapath_ctrl;
   typedef struct packed {
      logic        w, ill;
      logic [2:0]  rn, wn;
      logic        wr, la, lb, lc, ls, as, bs;
      logic [1:0]  vs, sh, op;
      logic [15:0] imm;
   } ov_t;

   logic        clk = 0, reset_n = 0, s = 0;
   logic [15:0] instr = '0;
   logic        w, ill, write, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, shift, aluop;
   logic [15:0] sximm8;
   int          checks = 0, failures = 0;
   ov_t         q[$];

   datapath_ctrl #(.DW(16)) dut (
      .clk(clk), .reset_n(reset_n), .s(s), .instr(instr), .w(w), .ill(ill),
      .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
      .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
      .vsel(vsel), .shift(shift), .aluop(aluop), .sximm8(sximm8)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic ov_t sample();
      return {w, ill, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, aluop, sximm8};
   endfunction

   function automatic ov_t base(input logic [15:0] i);
      ov_t v = '0;
      v.sh  = i[4:3];
      v.op  = i[12:11];
      v.imm = {{8{i[7]}}, i[7:0]};
      return v;
   endfunction

   task automatic check(input ov_t got, input ov_t exp, input string tag);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // expected output vector for each cycle from DECODE through the return to WAIT
   task automatic push_seq(input logic [15:0] i);
      ov_t v;
      logic [2:0] opc = i[15:13];
      logic [1:0] op  = i[12:11];
      bit movi = opc == 3'b110 && op == 2'b10;
      bit movr = opc == 3'b110 && op == 2'b00;
      bit alu  = opc == 3'b101;
      bit mvn  = alu && op == 2'b11;
      bit cmp  = alu && op == 2'b01;
      v = base(i); v.ill = !(movi || movr || alu); q.push_back(v);
      if (movi) begin
         v = base(i); v.wr = 1; v.wn = i[10:8]; v.vs = 2'b10; q.push_back(v);
      end else if (movr || alu) begin
         if (!(movr || mvn)) begin
            v = base(i); v.la = 1; v.rn = i[10:8]; q.push_back(v);
         end
         v = base(i); v.lb = 1; v.rn = i[2:0]; q.push_back(v);
         v = base(i); v.as = movr || mvn; v.lc = !cmp; v.ls = cmp; q.push_back(v);
         if (!cmp) begin
            v = base(i); v.wr = 1; v.wn = i[7:5]; q.push_back(v);
         end
      end
      v = base(i); v.w = 1; q.push_back(v);
   endtask

   // called just after a negedge with the DUT in WAIT; garbage on instr while busy must be ignored
   task automatic run(input logic [15:0] i, input bit keep, input string tag);
      int k = 0;
      instr = i;
      s = 1;
      push_seq(i);
      while (q.size() > 0) begin
         @(negedge clk);
         if (!keep) s = 0;
         instr = ~i;
         check(sample(), q.pop_front(), $sformatf("%s_c%0d", tag, k));
         k++;
      end
   endtask

   initial begin
      ov_t rv, v;
      rv = '0;
      rv.w = 1;
      #3 check(sample(), rv, "reset_async");
      @(negedge clk) check(sample(), rv, "reset_held");
      reset_n = 1;
      @(negedge clk) check(sample(), rv, "reset_release");
      run(16'hD105, 0, "movi_5");
      run(16'hD2FF, 0, "movi_m1");
      run(16'hA1A2, 0, "add");
      run(16'hA902, 0, "cmp");
      run(16'hB8E3, 0, "mvn");
      run(16'h0000, 0, "illegal");
      run(16'hC0F3, 0, "movr_sh");
      run(16'hB1A2, 0, "and");
      run(16'hD580, 0, "movi_m128");
      run(16'hA1A2, 1, "b2b_add");
      run(16'h0000, 1, "b2b_ill");
      run(16'hD105, 1, "b2b_movi");
      run(16'hC0F3, 1, "b2b_movr");
      run(16'hE000, 1, "b2b_ill7");
      run(16'hA902, 1, "b2b_cmp");
      run(16'hCFFF, 1, "b2b_ill_c3");
      s = 0;
      instr = 16'hA1A2;
      s = 1;
      @(negedge clk) s = 0;
      @(negedge clk);
      @(negedge clk);
      v = base(16'hA1A2); v.lb = 1; v.rn = 3'd2;
      check(sample(), v, "mid_getb");
      #2 reset_n = 0;
      #1 check(sample(), rv, "mid_reset_drop");
      @(negedge clk) check(sample(), rv, "mid_reset_held");
      reset_n = 1;
      @(negedge clk) check(sample(), rv, "mid_reset_wait");
      run(16'hD2FF, 0, "post_reset");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
